// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Request/response bundle between the requesting datapath blocks and the
//   shared-multiplier arbiter. Requester i owns req_a/req_b bits [32*i+31:32*i].
//   The slave modport is the arbiter side; the master modport is the
//   requester/consumer side.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [63:0]           resp_product;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one 32x32 unsigned multiplier among NUM_REQ requesters. One
//   operation is in flight at a time: IDLE (grant) -> CALC (multiply) ->
//   DONE (hold response until consumed). The response carries the index of
//   the requester that owns the product.
//
//   Configuration macro: MULT_SHARE_FIXED_PRI_EN
//     defined   -> fixed priority, lowest valid index wins, no rotation pointer
//     undefined -> round-robin starting at the pointer (default build)

// Combinational 32x32 -> 64 unsigned multiplier owned by the arbiter.
module umultiplier (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);
  assign o_p = {32'd0, i_a} * {32'd0, i_b};
endmodule

// Protocol checks on the arbiter's outputs; kept out of the datapath module.
module mult_share_arbiter_chk #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  input logic [NUM_REQ-1:0] i_req_ready,
  input logic               i_busy,
  input logic               i_resp_valid,
  input logic               i_resp_ready,
  input logic [ID_W-1:0]    i_resp_id,
  input logic [63:0]        i_resp_product
);
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(i_req_ready));

  a_no_grant_when_busy: assert property (@(posedge i_clk) disable iff (i_rst)
    i_busy |-> (i_req_ready == '0));

  a_resp_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (i_resp_valid && !i_resp_ready) |=>
      (i_resp_valid && $stable(i_resp_id) && $stable(i_resp_product)));
endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic                 i_clk,
  input logic                 i_rst,
  mult_share_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [ID_W-1:0]    r_id;
  logic [63:0]        r_product;
  logic [ID_W-1:0]    r_resp_id;
  logic               r_resp_valid;
  logic               r_busy;

  logic [ID_W-1:0]    w_start;
  logic [ID_W:0]      w_find;
  logic               w_found;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [63:0]        w_mult;

  // Search the valid vector for the first requester at or after i_start,
  // wrapping past NUM_REQ-1 to 0. Returns {found, index}.
  function automatic logic [ID_W:0] f_find(
    input logic [NUM_REQ-1:0] i_valid,
    input logic [ID_W-1:0]    i_start
  );
    logic [ID_W:0] v_res;
    int            v_best;
    int            v_off;
    v_res  = '0;
    v_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_off = (i + NUM_REQ - int'(i_start)) % NUM_REQ;
      if (i_valid[i] && (v_off < v_best)) begin
        v_best = v_off;
        v_res  = {1'b1, ID_W'(i)};
      end
    end
    return v_res;
  endfunction

`ifdef MULT_SHARE_FIXED_PRI_EN
  // Fixed priority: the search always starts at index 0.
  assign w_start = '0;
`else
  logic [ID_W-1:0] r_rr_ptr;

  assign w_start = r_rr_ptr;

  // Rotate the pointer to just past the requester taken on each accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_id + ID_W'(1));
    end
  end
`endif

  assign w_find     = f_find(io_bus.req_valid, w_start);
  assign w_found    = w_find[ID_W];
  assign w_grant_id = w_find[ID_W-1:0];

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and grant: a grant is offered only in IDLE and never while
  // reset is asserted; the response handshake cycle never grants.
  always_comb begin
    w_state_next = r_state;
    w_grant      = '0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && !i_rst) begin
          w_grant      = NUM_REQ'(1) << w_grant_id;
          w_accept     = 1'b1;
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (io_bus.resp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // One-hot AND-OR mux selecting the granted requester's operands.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_a = w_sel_a | (io_bus.req_a[32*i +: 32] & {32{w_grant[i]}});
      w_sel_b = w_sel_b | (io_bus.req_b[32*i +: 32] & {32{w_grant[i]}});
    end
  end

  umultiplier u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_mult)
  );

  // Capture operands and owner on accept; capture the product at end of CALC.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_product <= '0;
      r_resp_id <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        r_id <= w_grant_id;
      end
      if (r_state == ST_CALC) begin
        r_product <= w_mult;
        r_resp_id <= r_id;
      end
    end
  end

  // Status flags registered from the next state so they align with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_resp_valid <= (w_state_next == ST_DONE);
      r_busy       <= (w_state_next != ST_IDLE);
    end
  end

  assign io_bus.req_ready    = w_grant;
  assign io_bus.resp_valid   = r_resp_valid;
  assign io_bus.resp_id      = r_resp_id;
  assign io_bus.resp_product = r_product;
  assign io_bus.busy         = r_busy;

  mult_share_arbiter_chk #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_chk (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_ready    (w_grant),
    .i_busy         (r_busy),
    .i_resp_valid   (r_resp_valid),
    .i_resp_ready   (io_bus.resp_ready),
    .i_resp_id      (r_resp_id),
    .i_resp_product (r_product)
  );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Scoreboard bench: the driver keeps an abstract model (phase of the single
//   in-flight operation, rotation pointer, pending requests) and pushes the
//   expected {id, a*b} when the model grants; an independent monitor compares
//   every presented response against the queue head and pops on handshake.
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     prod;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  exp_t        exp_q[$];
  int          grant_log[$];

  logic        pend_v[NUM_REQ];
  logic [31:0] pend_a[NUM_REQ];
  logic [31:0] pend_b[NUM_REQ];
  logic        drv_resp_ready;
  int          m_phase;   // 0: no operation, 1: multiplying, 2: result waiting
  int          m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Spec rule: first pending index searching upward from the pointer, wrapping.
  function automatic int model_pick();
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx = (m_ptr + k) % NUM_REQ;
      if (pend_v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check model vs DUT status, advance model.
  task automatic run_cycle(input logic do_rst);
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]        = pend_v[i];
      bus.req_a[32*i +: 32]   = pend_a[i];
      bus.req_b[32*i +: 32]   = pend_b[i];
    end
    bus.resp_ready = drv_resp_ready;
    #1;
    check("busy", {63'd0, bus.busy}, {63'd0, (m_phase != 0)});
    check("resp_valid", {63'd0, bus.resp_valid}, {63'd0, (m_phase == 2)});
    exp_rdy = '0;
    g = -1;
    if (m_phase == 0 && !do_rst) begin
      g = model_pick();
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_ready", {60'd0, bus.req_ready}, {60'd0, exp_rdy});
    if (!do_rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i] === 1'b1 && bus.req_valid[i] === 1'b1) grant_log.push_back(i);
    end
    if (do_rst) begin
      m_phase = 0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        exp_t e;
        e.id   = ID_W'(g);
        e.prod = {32'd0, pend_a[g]} * {32'd0, pend_b[g]};
        exp_q.push_back(e);
        pend_v[g] = 1'b0;
`ifdef MULT_SHARE_FIXED_PRI_EN
        m_ptr = 0;
`else
        m_ptr = (g + 1) % NUM_REQ;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (drv_resp_ready) begin
      m_phase = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    drv_resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (m_phase == 0 && exp_q.size() == 0) break;
      run_cycle(1'b0);
      #3;
    end
    if (!(m_phase == 0 && exp_q.size() == 0)) begin
      n_total++;
      $display("FAIL drain_timeout: phase %0d, %0d responses outstanding, expected none", m_phase, exp_q.size());
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
  endtask

  // Monitor: compare every presented response with the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (bus.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: got id %0d product %h, expected no response", bus.resp_id, bus.resp_product);
        end else begin
          check("resp_id", {62'd0, bus.resp_id}, {62'd0, exp_q[0].id});
          check("resp_product", bus.resp_product, exp_q[0].prod);
          if (bus.resp_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    int exp_rr[6];
    int exp_p23[4];
    m_phase = 0;
    m_ptr   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = 32'd0;
      pend_b[i] = 32'd0;
    end
    rst            = 1'b1;
    drv_resp_ready = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_resp_id", {62'd0, bus.resp_id}, 64'd0);
    check("rst_resp_product", bus.resp_product, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);

    // Single request from requester 1.
    drv_resp_ready = 1'b1;
    set_req(1, 32'd3, 32'd5);
    drain();
    set_req(1, 32'd3, 32'd5);
    for (int k = 0; k < 4; k++) run_cycle(1'b0);
    drain();

    // Backpressure with maximal operands; another requester waits meanwhile.
    set_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drv_resp_ready = 1'b0;
    run_cycle(1'b0);
    set_req(1, 32'h12345678, 32'h9ABCDEF0);
    run_cycle(1'b0);
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0);
      check("bp_product", bus.resp_product, 64'hFFFFFFFE00000001);
    end
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    drv_resp_ready = 1'b1;
    run_cycle(1'b0);
    run_cycle(1'b0);
    drain();

    // Reset while multiplying: operation abandoned, pointer back to 0.
    set_req(2, 32'd7, 32'd9);
    run_cycle(1'b0);
    pend_v[2] = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b0);
    check("post_rst_resp_id", {62'd0, bus.resp_id}, 64'd0);
    check("post_rst_product", bus.resp_product, 64'd0);
    for (int k = 0; k < 4; k++) run_cycle(1'b0);

    // All requesters valid continuously.
    grant_log.delete();
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend_v[i]) set_req(i, $urandom, $urandom);
      run_cycle(1'b0);
    end
    drain();
`ifdef MULT_SHARE_FIXED_PRI_EN
    exp_rr = '{0, 0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0, 1};
`endif
    check("rr_count", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check("rr_order", 64'(grant_log[k]), 64'(exp_rr[k]));

    // Zero operand from requester 3, then all valid.
    set_req(3, 32'd0, 32'hDEADBEEF);
    run_cycle(1'b0);
    drain();
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom);
    run_cycle(1'b0);
    check("wrap_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFFFF, 64'd0);
    drain();

    // Requesters 2 and 3 valid continuously.
    grant_log.delete();
    for (int k = 0; k < 12; k++) begin
      for (int i = 2; i < NUM_REQ; i++)
        if (!pend_v[i]) set_req(i, $urandom, $urandom);
      run_cycle(1'b0);
    end
    drain();
`ifdef MULT_SHARE_FIXED_PRI_EN
    exp_p23 = '{2, 2, 2, 2};
`else
    exp_p23 = '{2, 3, 2, 3};
`endif
    check("p23_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("p23_order", 64'(grant_log[k]), 64'(exp_p23[k]));

    // Randomized traffic with random backpressure and request withdrawal.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 5))
              0:       set_req(i, 32'd0, $urandom);
              1:       set_req(i, 32'hFFFFFFFF, $urandom);
              default: set_req(i, $urandom, $urandom);
            endcase
          end
        end else if ($urandom_range(0, 19) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      drv_resp_ready = ($urandom_range(0, 3) != 0);
      run_cycle(1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
